// File: rtl/fp8_accum_seq.sv
`default_nettype none
// ============================================================================
// fp8_accum_seq : sequencer summing a stream of 1-4-3 minifloats via an
//                 external registered FP8 adder.      Revision: 1.0
// ============================================================================
module fp8_accum_seq #(
  parameter int ADD_LAT = 1,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_en,
  input  logic [7:0]       add_res,
  output logic [7:0]       sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int                WCNT_W      = $clog2(ADD_LAT + 2);
  localparam logic [WCNT_W-1:0] C_WCNT_LAST = WCNT_W'(ADD_LAT);
  localparam logic [LEN_W-1:0]  C_REM_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_acc, w_acc_nxt;
  logic [7:0]        r_add_a, w_add_a_nxt;
  logic [7:0]        r_add_b, w_add_b_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [LEN_W-1:0]  r_rem, w_rem_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic              r_first, w_first_nxt;
  logic              r_ovf, w_ovf_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 8'h00;
      r_add_a <= 8'h00;
      r_add_b <= 8'h00;
      r_sum   <= 8'h00;
      r_rem   <= '0;
      r_wcnt  <= '0;
      r_first <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_add_a <= w_add_a_nxt;
      r_add_b <= w_add_b_nxt;
      r_sum   <= w_sum_nxt;
      r_rem   <= w_rem_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_first <= w_first_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // sum is loaded on the edge entering DONE so it is already valid there
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_add_a_nxt = r_add_a;
    w_add_b_nxt = r_add_b;
    w_sum_nxt   = r_sum;
    w_rem_nxt   = r_rem;
    w_wcnt_nxt  = r_wcnt;
    w_first_nxt = r_first;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ovf_nxt = 1'b0;
          if (len == '0) begin
            w_acc_nxt   = 8'h00;
            w_sum_nxt   = 8'h00;
            w_state_nxt = S_DONE;
          end else begin
            w_rem_nxt   = len;
            w_first_nxt = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (r_first) begin
            // first operand bypasses the adder so a lone operand stays exact
            w_acc_nxt   = in_data;
            w_first_nxt = 1'b0;
            w_rem_nxt   = r_rem - C_REM_ONE;
            if (r_rem == C_REM_ONE) begin
              w_sum_nxt   = in_data;
              w_state_nxt = S_DONE;
            end
          end else begin
            w_add_a_nxt = r_acc;
            w_add_b_nxt = in_data;
            w_wcnt_nxt  = '0;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_wcnt_nxt = r_wcnt + 1'b1;
        if (r_wcnt == C_WCNT_LAST) begin
          w_acc_nxt = add_res;
          w_rem_nxt = r_rem - C_REM_ONE;
          w_ovf_nxt = r_ovf | (add_res[6:3] == 4'hF);
          if (r_rem == C_REM_ONE) begin
            w_sum_nxt   = add_res;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_LOAD);
  assign add_en    = (r_state == S_EXEC);
  assign sum_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign sum       = r_sum;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp8_accum_seq.sv
`default_nettype none
// ============================================================================
// tb_fp8_accum_seq : directed bench for fp8_accum_seq with a stub adder.
// ============================================================================
module tb_fp8_accum_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] add_a, add_b;
  logic       add_en;
  logic [7:0] add_res;
  logic [7:0] sum;
  logic       sum_valid;
  logic       busy;
  logic       ovf;

  logic [7:0] stub_res;
  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  int sv_cnt   = 0;
  int rdy_cnt  = 0;
  int snap_en, snap_sv, snap_rdy;

  always #5 clk = ~clk;

  fp8_accum_seq #(.ADD_LAT(1), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_res(add_res),
    .sum(sum), .sum_valid(sum_valid), .busy(busy), .ovf(ovf)
  );

  // Stub adder: one-cycle registered result, zero while idle
  always @(posedge clk) add_res <= add_en ? stub_res : 8'h00;

  always @(posedge clk) begin
    if (add_en)    en_cnt  <= en_cnt + 1;
    if (sum_valid) sv_cnt  <= sv_cnt + 1;
    if (in_ready)  rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0; len = 4'd0;
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    in_data = d; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic wait_ready;
    int t;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_done;
    int t;
    t = 0;
    while (!sum_valid && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) check("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 4'd0; in_data = 8'h00; in_valid = 1'b0;
    stub_res = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_add_en", add_en, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_add_ab", {add_a, add_b}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single operand passes straight through
    snap_en = en_cnt; snap_sv = sv_cnt;
    do_start(4'd1);
    check("t1_busy", busy, 1);
    send(8'h3A);
    check("t1_sum_valid", sum_valid, 1);
    check("t1_sum", sum, 8'h3A);
    @(negedge clk);
    check("t1_sum_hold", sum, 8'h3A);
    check("t1_sv_pulses", sv_cnt - snap_sv, 1);
    check("t1_add_en_cnt", en_cnt - snap_en, 0);
    check("t1_ovf", ovf, 0);
    check("t1_idle", busy, 0);

    // 2: two operands, one add
    stub_res = 8'h40;
    snap_en = en_cnt;
    do_start(4'd2);
    send(8'h38);
    send(8'h38);
    check("t2_add_en", add_en, 1);
    check("t2_add_a", add_a, 8'h38);
    check("t2_add_b", add_b, 8'h38);
    wait_done;
    check("t2_sum", sum, 8'h40);
    check("t2_add_en_cnt", en_cnt - snap_en, 2);
    @(negedge clk);
    check("t2_ab_hold_idle", {add_a, add_b}, 16'h3838);
    check("t2_ovf", ovf, 0);

    // 3: empty sum
    snap_rdy = rdy_cnt;
    start = 1'b1; len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("t3_sum_valid", sum_valid, 1);
    check("t3_sum", sum, 8'h00);
    @(negedge clk);
    check("t3_sum_valid_off", sum_valid, 0);
    check("t3_no_ready", rdy_cnt - snap_rdy, 0);

    // 4: LOAD stalls without valid data
    do_start(4'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_ready_stall", in_ready, 1);
      @(negedge clk);
    end
    check("t4_busy_stall", busy, 1);
    send(8'h55);
    check("t4_sum_valid", sum_valid, 1);
    check("t4_sum", sum, 8'h55);
    @(negedge clk);

    // 5: overflow on the second add is sticky until the next start
    stub_res = 8'h50;
    do_start(4'd3);
    send(8'h08);
    send(8'h10);
    wait_ready;
    check("t5_ovf_mid", ovf, 0);
    stub_res = 8'h79;
    send(8'h18);
    check("t5_add_a", add_a, 8'h50);
    check("t5_add_b", add_b, 8'h18);
    wait_done;
    check("t5_sum", sum, 8'h79);
    check("t5_ovf_done", ovf, 1);
    @(negedge clk);
    check("t5_ovf_sticky", ovf, 1);
    start = 1'b1; len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("t5_ovf_cleared", ovf, 0);
    @(negedge clk);

    // 6: start during EXEC ignored; reset during EXEC abandons
    stub_res = 8'h44;
    do_start(4'd2);
    send(8'h20);
    send(8'h22);
    check("t6_in_exec", add_en, 1);
    start = 1'b1; len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done;
    check("t6_sum_ignored_start", sum, 8'h44);
    @(negedge clk);
    check("t6_idle_after", busy, 0);

    stub_res = 8'h7A;
    do_start(4'd2);
    send(8'h20);
    send(8'h22);
    check("t6b_in_exec", add_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6b_busy", busy, 0);
    check("t6b_add_en", add_en, 0);
    check("t6b_ready", in_ready, 0);
    check("t6b_sum_valid", sum_valid, 0);
    check("t6b_sum", sum, 8'h00);
    check("t6b_add_ab", {add_a, add_b}, 16'h0000);
    check("t6b_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6b_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
